// File: rtl/ll_pop_scheduler_pkg.sv
// Shared linked-list FIFO parameters and helpers used by the pop scheduler.
package ll_pop_scheduler_pkg;

    localparam int unsigned LL_WIDTH     = 4;
    localparam int unsigned LL_NUM_FIFOS = 2;

    // Queue-select width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LL_SEL_WIDTH = sel_width(LL_NUM_FIFOS);

endpackage

// File: rtl/ll_pop_scheduler_if.sv
// Pop-side and downstream signals of the scheduler, bundled for port connection.
interface ll_pop_scheduler_if
    import ll_pop_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH     = LL_WIDTH,
    parameter int unsigned NUM_FIFOS = LL_NUM_FIFOS,
    parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) ();

    logic [NUM_FIFOS-1:0] empty;
    logic [WIDTH-1:0]     data_out;
    logic [NUM_FIFOS-1:0] q_en;
    logic                 pop;
    logic [SEL_WIDTH-1:0] pop_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_qid;
    logic [15:0]          pop_cnt;

    modport master (
        input  empty, data_out, q_en, out_ready,
        output pop, pop_sel, out_valid, out_data, out_qid, pop_cnt
    );

    modport slave (
        output empty, data_out, q_en, out_ready,
        input  pop, pop_sel, out_valid, out_data, out_qid, pop_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting index at or after ptr, wrapping upward.
module rr_arbiter #(
    parameter int unsigned NUM_FIFOS = 2,
    parameter int unsigned SEL_WIDTH = 1
) (
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 gnt_vld,
    output logic [SEL_WIDTH-1:0] gnt_idx
);

    logic                 hi_found;
    logic [SEL_WIDTH-1:0] hi_idx;
    logic [SEL_WIDTH-1:0] lo_idx;

    // Descending scan leaves the lowest hit; hi_* only counts indices >= ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = SEL_WIDTH'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_WIDTH'(i);
                end
            end
        end
        gnt_vld = |req;
        if (hi_found) begin
            gnt_idx = hi_idx;
        end else if (gnt_vld) begin
            gnt_idx = lo_idx;
        end else begin
            gnt_idx = ptr;
        end
    end

endmodule

// File: rtl/ll_pop_scheduler.sv
// Round-robin pop scheduler for a shared multi-queue FIFO with a 2-entry output buffer.
module ll_pop_scheduler
    import ll_pop_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH     = LL_WIDTH,
    parameter int unsigned NUM_FIFOS = LL_NUM_FIFOS,
    parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
    input  logic               clk,
    input  logic               rst,
    ll_pop_scheduler_if.master bus
);

    localparam int unsigned ObW = SEL_WIDTH + WIDTH;

    logic [NUM_FIFOS-1:0] eligible;
    logic                 gnt_vld;
    logic [SEL_WIDTH-1:0] gnt_idx;
    logic                 space;
    logic                 ob_wr;
    logic                 ob_rd;

    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]          pop_cnt_q, pop_cnt_d;
    logic [1:0]           ob_cnt_q, ob_cnt_d;
    logic                 ob_wp_q, ob_wp_d;
    logic                 ob_rp_q, ob_rp_d;
    logic [ObW-1:0]       ob_mem_q [2];
    logic [ObW-1:0]       ob_mem_d [2];

    assign eligible = ~bus.empty & bus.q_en;

    rr_arbiter #(
        .NUM_FIFOS (NUM_FIFOS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        bus.out_valid = (ob_cnt_q != 2'd0);
        {bus.out_qid, bus.out_data} = ob_mem_q[ob_rp_q];
        bus.pop_sel   = gnt_idx;
        bus.pop_cnt   = pop_cnt_q;
        ob_rd         = bus.out_valid & bus.out_ready;
        // A draining head frees a slot in the same cycle, so a full buffer can still accept.
        space         = (ob_cnt_q < 2'd2) | ob_rd;
        bus.pop       = rst & gnt_vld & space;
        ob_wr         = bus.pop;
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        pop_cnt_d = pop_cnt_q;
        ob_cnt_d  = ob_cnt_q;
        ob_wp_d   = ob_wp_q;
        ob_rp_d   = ob_rp_q;
        ob_mem_d  = ob_mem_q;
        if (ob_wr) begin
            rr_ptr_d  = (gnt_idx == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : gnt_idx + SEL_WIDTH'(1);
            pop_cnt_d = pop_cnt_q + 16'd1;
            ob_mem_d[ob_wp_q] = {gnt_idx, bus.data_out};
            ob_wp_d   = ~ob_wp_q;
        end
        if (ob_rd) begin
            ob_rp_d = ~ob_rp_q;
        end
        if (ob_wr && !ob_rd) begin
            ob_cnt_d = ob_cnt_q + 2'd1;
        end else if (!ob_wr && ob_rd) begin
            ob_cnt_d = ob_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            pop_cnt_q   <= '0;
            ob_cnt_q    <= '0;
            ob_wp_q     <= 1'b0;
            ob_rp_q     <= 1'b0;
            ob_mem_q[0] <= '0;
            ob_mem_q[1] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pop_cnt_q   <= pop_cnt_d;
            ob_cnt_q    <= ob_cnt_d;
            ob_wp_q     <= ob_wp_d;
            ob_rp_q     <= ob_rp_d;
            ob_mem_q[0] <= ob_mem_d[0];
            ob_mem_q[1] <= ob_mem_d[1];
        end
    end

endmodule

// File: tb/tb_ll_pop_scheduler.sv
// Directed plus randomized bench for ll_pop_scheduler with a queue-based reference model.
module tb_ll_pop_scheduler;

    localparam int NQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ll_pop_scheduler_if #(.WIDTH(4), .NUM_FIFOS(NQ), .SEL_WIDTH(2)) bus ();

    ll_pop_scheduler #(
        .WIDTH     (4),
        .NUM_FIFOS (NQ),
        .SEL_WIDTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared FIFO stand-in: head word of the selected queue, same cycle.
    logic [3:0] head_val [NQ];
    assign bus.data_out = head_val[bus.pop_sel];

    int passed = 0;
    int total  = 0;
    int npop   = 0;
    bit rand_heads = 1'b1;

    // Reference state: output buffer contents as {qid, data}, rr pointer, pop counter.
    logic [5:0]  m_ob [$];
    int          m_ptr = 0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ob.delete();
        m_ptr = 0;
        m_cnt = '0;
    endtask

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic run_cycle();
        logic [NQ-1:0] elig;
        int  sel;
        bit  found;
        bit  exp_valid, exp_space, exp_pop;
        if (rand_heads) begin
            for (int q = 0; q < NQ; q++) head_val[q] = 4'($urandom_range(15));
        end
        #1;
        elig  = ~bus.empty & bus.q_en;
        sel   = m_ptr;
        found = 1'b0;
        for (int k = 0; k < NQ; k++) begin
            if (!found && elig[(m_ptr + k) % NQ]) begin
                sel   = (m_ptr + k) % NQ;
                found = 1'b1;
            end
        end
        exp_valid = (m_ob.size() > 0);
        exp_space = (m_ob.size() < 2) || (exp_valid && bus.out_ready);
        exp_pop   = found && exp_space;
        chk("pop", 32'(bus.pop), 32'(exp_pop));
        chk("pop_sel", 32'(bus.pop_sel), 32'(sel));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("pop_cnt", 32'(bus.pop_cnt), 32'(m_cnt));
        if (exp_valid) begin
            chk("out_qid", 32'(bus.out_qid), 32'(m_ob[0][5:4]));
            chk("out_data", 32'(bus.out_data), 32'(m_ob[0][3:0]));
        end
        if (bus.pop) begin
            chk("pop_on_empty", 32'(bus.empty[bus.pop_sel]), 32'(0));
            npop++;
        end
        if (exp_valid && bus.out_ready) void'(m_ob.pop_front());
        if (exp_pop) begin
            m_ob.push_back({2'(sel), head_val[sel]});
            m_ptr = (sel + 1) % NQ;
            m_cnt = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int q = 0; q < NQ; q++) head_val[q] = '0;
        bus.empty     = '1;
        bus.q_en      = '1;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_pop", 32'(bus.pop), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_pop_cnt", 32'(bus.pop_cnt), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_out_qid", 32'(bus.out_qid), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        // Idle with every queue empty.
        repeat (3) run_cycle();

        // All eligible, downstream always ready: strict rotation 0..3.
        bus.empty     = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rotation_sel", 32'(bus.pop_sel), 32'(i % NQ));
            run_cycle();
        end
        chk("rotation_cnt", 32'(bus.pop_cnt), 32'(8));

        // Drain, then stall downstream with only queue 2 holding data.
        bus.empty = '1;
        repeat (2) run_cycle();
        bus.empty     = 4'b1011;
        bus.out_ready = 1'b0;
        npop = 0;
        repeat (5) run_cycle();
        chk("stall_pops", 32'(npop), 32'(2));
        bus.out_ready = 1'b1;
        #1;
        chk("resume_pop", 32'(bus.pop), 32'(1));
        repeat (4) run_cycle();

        // Queue 2 masked, queues 1 and 3 empty: only queue 0 may win.
        bus.empty = 4'b1010;
        bus.q_en  = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("masked_sel", 32'(bus.pop_sel), 32'(0));
            run_cycle();
        end

        // Distinct head words on queues 1 and 3.
        bus.empty = '1;
        bus.q_en  = '1;
        repeat (2) run_cycle();
        rand_heads  = 1'b0;
        head_val[1] = 4'hA;
        head_val[3] = 4'h5;
        bus.empty   = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.out_valid) begin
                chk("pair_data", 32'(bus.out_data), (bus.out_qid == 2'd1) ? 32'hA : 32'h5);
            end
            run_cycle();
        end
        rand_heads = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bus.empty     = 4'($urandom_range(15));
            bus.q_en      = 4'($urandom_range(15));
            bus.out_ready = ($urandom_range(3) != 0);
            run_cycle();
        end

        // Fill the buffer, then pulse reset between clock edges.
        bus.empty     = '0;
        bus.q_en      = '1;
        bus.out_ready = 1'b0;
        repeat (3) run_cycle();
        chk("full_before_rst", 32'(m_ob.size()), 32'(2));
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_pop_cnt", 32'(bus.pop_cnt), 32'(0));
        chk("midrst_pop", 32'(bus.pop), 32'(0));
        chk("midrst_out_qid", 32'(bus.out_qid), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) run_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ll_pop_scheduler.md
LL_POP_SCHEDULER -- requirements
Module: ll_pop_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the data word width, equal to the shared FIFO's width.
REQ-002 SHALL have parameter NUM_FIFOS, default 2, meaning the number of logical queues in the shared FIFO.
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(NUM_FIFOS) (minimum 1), meaning the queue-select width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (asserted at 0).
REQ-006 SHALL have port empty, input, NUM_FIFOS bits: per-queue empty flags from the shared FIFO.
REQ-007 SHALL have port data_out, input, WIDTH bits: the shared FIFO head word for pop_sel, valid in the same cycle as pop.
REQ-008 SHALL have port q_en, input, NUM_FIFOS bits: per-queue scheduling enable mask.
REQ-009 SHALL have port pop, output, 1 bit: pop request to the shared FIFO.
REQ-010 SHALL have port pop_sel, output, SEL_WIDTH bits: the queue being popped.
REQ-011 SHALL have port out_valid, output, 1 bit: downstream word valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port out_data, output, WIDTH bits: downstream word.
REQ-014 SHALL have port out_qid, output, SEL_WIDTH bits: source queue of out_data.
REQ-015 SHALL have port pop_cnt, output, 16 bits: total pops since reset, wrapping.

Function
REQ-016 SHALL compute eligible[i] = ~empty[i] & q_en[i]; pop SHALL never assert for a queue that is empty (the FIFO's no-pop-when-empty rule).
REQ-017 SHALL select the grant round-robin: the first eligible index at or after rr_ptr, searching upward modulo NUM_FIFOS.
REQ-018 SHALL drive pop_sel to the granted index combinationally; when no queue is eligible, pop_sel SHALL hold rr_ptr.
REQ-019 SHALL buffer output words in a 2-entry FIFO (ob) holding {qid, data}; ob_cnt ranges 0..2.
REQ-020 SHALL compute space = (ob_cnt < 2) | (out_valid & out_ready).
REQ-021 SHALL set pop = |eligible & space, combinationally, with 0 cycles of pop latency.
REQ-022 SHALL, on a pop cycle, write {pop_sel, data_out} into ob at the rising edge; the word becomes visible on out_* the next cycle if ob was empty.
REQ-023 SHALL, on a pop, set rr_ptr to (pop_sel+1) mod NUM_FIFOS; otherwise rr_ptr SHALL hold.
REQ-024 SHALL set out_valid = (ob_cnt != 0), with out_data/out_qid taken from the ob head.
REQ-025 SHALL hold out_data/out_qid stable while out_valid & ~out_ready.
REQ-026 SHALL, on simultaneous ob write and read, leave ob_cnt unchanged and preserve word order; sustained throughput SHALL be 1 word/cycle.
REQ-027 SHALL, when ob_cnt==2 & ~out_ready, keep pop=0 regardless of eligibility.
REQ-028 SHALL increment pop_cnt by 1 on each pop cycle, wrapping 0xFFFF to 0.
REQ-029 SHALL make q_en changes effective in the same cycle; words already in ob are unaffected.
REQ-030 SHALL keep per-queue word order: words from one queue leave in pop order.

Reset
REQ-031 SHALL, while rst==0, drive ob_cnt=0, ob read/write pointers=0, rr_ptr=0, pop_cnt=0, out_valid=0, out_data=0, out_qid=0.
REQ-032 SHALL force pop=0 while rst==0.
REQ-033 SHALL, on reset mid-operation, discard buffered words; the shared FIFO is reset by the same rst domain.

Structure
REQ-034 SHALL place the WIDTH/NUM_FIFOS defaults and the derived SEL_WIDTH in the shared linked-list package with the shared FIFO.
REQ-035 SHALL implement the round-robin search in a sub-module rr_arbiter (inputs: req vector, ptr; outputs: gnt_vld, gnt_idx).
REQ-036 SHALL implement ob inline as two registers plus 1-bit read/write pointers.

Verification (NUM_FIFOS=4, WIDTH=4)
REQ-037 SHALL cover: reset released, all empty=1 -> pop=0, out_valid=0, pop_cnt=0.
REQ-038 SHALL cover: empty=4'b0000, q_en=4'hF, out_ready=1 for 8 cycles -> pop_sel sequence 0,1,2,3,0,1,2,3, pop_cnt=8.
REQ-039 SHALL cover: out_ready=0 with queue 2 non-empty -> exactly 2 pops, then pop=0; when out_ready=1, words drain in order and popping resumes in the same cycle.
REQ-040 SHALL cover: empty=4'b1010, q_en=4'b1011 -> grants alternate only 0 and 0 (queue 2 is masked, queues 1 and 3 are empty); pop never asserts with empty[pop_sel]=1.
REQ-041 SHALL cover: rst pulsed low while ob_cnt=2 -> out_valid=0 and pop_cnt=0 immediately, before the clock edge.
REQ-042 SHALL cover: data_out=0xA for queue 1 and 0x5 for queue 3 -> out_data/out_qid pairs (0xA,1),(0x5,3) in grant order.
